// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller and its density front end.
package tlc_pkg;

    localparam int ROAD_A    = 0;
    localparam int ROAD_B    = 1;
    localparam int ROAD_C    = 2;
    localparam int ROAD_D    = 3;
    localparam int NUM_ROADS = 4;

    localparam int DEF_WINDOW   = 256;
    localparam int DEF_DEBOUNCE = 4;
    localparam int DEF_T1       = 2;
    localparam int DEF_T2       = 5;
    localparam int DEF_T3       = 9;
    localparam int DEF_CNT_W    = 8;

    localparam int CODE_W = 3;
    typedef logic [CODE_W-1:0] code_t;

    // Bit 0 is level 1 (x1), bit 2 is level 3 (x3).
    function automatic code_t density_code(int unsigned count, int unsigned t1,
                                           int unsigned t2, int unsigned t3);
        density_code = {count >= t3, count >= t2, count >= t1};
    endfunction

endpackage

// File: rtl/tlc_density_sensor_if.sv
// Detector inputs and density snapshot outputs of the density sensor.
interface tlc_density_sensor_if;

    logic [3:0] det;
    logic       a1, a2, a3;
    logic       b1, b2, b3;
    logic       c1, c2, c3;
    logic       d1, d2, d3;
    logic       density_update;

    modport master (
        output det,
        input  a1, a2, a3, b1, b2, b3, c1, c2, c3, d1, d2, d3, density_update
    );

    modport slave (
        input  det,
        output a1, a2, a3, b1, b2, b3, c1, c2, c3, d1, d2, d3, density_update
    );

endinterface

// File: rtl/tlc_det_channel.sv
// One road: debounce, arrival edge detect, saturating count, threshold code register.
module tlc_det_channel
    import tlc_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE,
    parameter int T1       = DEF_T1,
    parameter int T2       = DEF_T2,
    parameter int T3       = DEF_T3,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic  clock,
    input  logic  clear,
    input  logic  det_i,
    input  logic  close,
    output code_t code_o
);

    localparam int DB_W = $clog2(DEBOUNCE + 1);

    logic             lvl_q, lvl_d;
    logic             prev_q, prev_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_next;
    code_t            code_q, code_d;
    logic             rise;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
        lvl_d    = lvl_q;
        prev_d   = lvl_q;
        db_cnt_d = '0;
        code_d   = code_q;

        // The DEBOUNCE-th consecutive differing sample is accepted; the counter then restarts.
        if (det_i != lvl_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE - 1)) begin
                lvl_d = det_i;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        rise     = lvl_q & ~prev_q;
        cnt_next = cnt_q;
        if (rise && (cnt_q != '1)) begin
            cnt_next = cnt_q + CNT_W'(1);
        end

        cnt_d = cnt_next;
        if (close) begin
            code_d = density_code(32'(cnt_next), T1, T2, T3);
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values; clear is synchronous.
        if (clear) begin
            lvl_q    <= 1'b0;
            prev_q   <= 1'b0;
            db_cnt_q <= '0;
            cnt_q    <= '0;
            code_q   <= '0;
        end else begin
            lvl_q    <= lvl_d;
            prev_q   <= prev_d;
            db_cnt_q <= db_cnt_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
        end
    end

    assign code_o = code_q;

endmodule

// File: rtl/tlc_density_sensor.sv
// Density sensor top: window timer, update pulse and fan-out of four road channels.
module tlc_density_sensor
    import tlc_pkg::*;
#(
    parameter int WINDOW   = DEF_WINDOW,
    parameter int DEBOUNCE = DEF_DEBOUNCE,
    parameter int T1       = DEF_T1,
    parameter int T2       = DEF_T2,
    parameter int T3       = DEF_T3,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                 clock,
    input  logic                 clear,
    tlc_density_sensor_if.slave  bus
);

    localparam int WIN_W = $clog2(WINDOW);

    logic [WIN_W-1:0] win_q, win_d;
    logic             upd_q, upd_d;
    logic             close;
    code_t            codes [NUM_ROADS];

    always_comb begin
        close = (win_q == WIN_W'(WINDOW - 1));
        win_d = close ? '0 : win_q + WIN_W'(1);
        upd_d = close;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            win_q <= '0;
            upd_q <= 1'b0;
        end else begin
            win_q <= win_d;
            upd_q <= upd_d;
        end
    end

    for (genvar i = 0; i < NUM_ROADS; i++) begin : g_road
        tlc_det_channel #(
            .DEBOUNCE (DEBOUNCE),
            .T1       (T1),
            .T2       (T2),
            .T3       (T3),
            .CNT_W    (CNT_W)
        ) u_channel (
            .clock  (clock),
            .clear  (clear),
            .det_i  (bus.det[i]),
            .close  (close),
            .code_o (codes[i])
        );
    end

    assign bus.density_update = upd_q;

    assign bus.a1 = codes[ROAD_A][0];
    assign bus.a2 = codes[ROAD_A][1];
    assign bus.a3 = codes[ROAD_A][2];
    assign bus.b1 = codes[ROAD_B][0];
    assign bus.b2 = codes[ROAD_B][1];
    assign bus.b3 = codes[ROAD_B][2];
    assign bus.c1 = codes[ROAD_C][0];
    assign bus.c2 = codes[ROAD_C][1];
    assign bus.c3 = codes[ROAD_C][2];
    assign bus.d1 = codes[ROAD_D][0];
    assign bus.d2 = codes[ROAD_D][1];
    assign bus.d3 = codes[ROAD_D][2];

endmodule

// File: tb/tb_tlc_density_sensor.sv
// Bench for tlc_density_sensor: a default instance and a T1=1 instance share the detector lines.
module tb_tlc_density_sensor;

    localparam int W   = 256;
    localparam int DEB = 4;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic [3:0] det   = 4'hF;

    int n_cmp = 0;
    int n_err = 0;

    tlc_density_sensor_if bus_d ();
    tlc_density_sensor_if bus_b ();
    assign bus_d.det = det;
    assign bus_b.det = det;

    tlc_density_sensor u_dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus_d)
    );

    tlc_density_sensor #(.T1(1)) u_dut_t1 (
        .clock (clock),
        .clear (clear),
        .bus   (bus_b)
    );

    always #5 clock = ~clock;

    // Observed codes per road, bit 0 = x1; road D is the most significant triple.
    logic [3:0][2:0] obs_d, obs_b;
    assign obs_d[0] = {bus_d.a3, bus_d.a2, bus_d.a1};
    assign obs_d[1] = {bus_d.b3, bus_d.b2, bus_d.b1};
    assign obs_d[2] = {bus_d.c3, bus_d.c2, bus_d.c1};
    assign obs_d[3] = {bus_d.d3, bus_d.d2, bus_d.d1};
    assign obs_b[0] = {bus_b.a3, bus_b.a2, bus_b.a1};
    assign obs_b[1] = {bus_b.b3, bus_b.b2, bus_b.b1};
    assign obs_b[2] = {bus_b.c3, bus_b.c2, bus_b.c1};
    assign obs_b[3] = {bus_b.d3, bus_b.d2, bus_b.d1};

    // Reference model: a level is accepted once the last DEB samples all disagree with it;
    // each accepted rise is one vehicle, credited to the window of the cycle it becomes visible.
    bit [3:0][2:0] exp_d   = '0;
    bit [3:0][2:0] exp_b   = '0;
    bit            exp_upd = 1'b0;
    int            m_pos   = 0;
    bit [3:0]      m_lvl   = '0;
    bit [3:0]      m_prev  = '0;
    int            m_cnt [4];
    logic [3:0]    hist [$];

    function automatic bit [2:0] model_code(int n, int t1);
        return {n >= 9, n >= 5, n >= t1};
    endfunction

    always @(posedge clock) begin
        bit all_diff;
        if (clear) begin
            exp_d = '0; exp_b = '0; exp_upd = 1'b0;
            m_pos = 0; m_lvl = '0; m_prev = '0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            hist.delete();
        end else begin
            for (int i = 0; i < 4; i++)
                if (m_lvl[i] && !m_prev[i] && m_cnt[i] < 255) m_cnt[i]++;
            exp_upd = (m_pos == W - 1);
            if (exp_upd) begin
                for (int i = 0; i < 4; i++) begin
                    exp_d[i] = model_code(m_cnt[i], 2);
                    exp_b[i] = model_code(m_cnt[i], 1);
                    m_cnt[i] = 0;
                end
            end
            m_pos = (m_pos + 1) % W;
            hist.push_back(det);
            if (hist.size() > DEB) void'(hist.pop_front());
            m_prev = m_lvl;
            for (int i = 0; i < 4; i++) begin
                all_diff = (hist.size() == DEB);
                foreach (hist[k]) if (hist[k][i] == m_lvl[i]) all_diff = 1'b0;
                if (all_diff) m_lvl[i] = ~m_lvl[i];
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse(logic [3:0] mask, int hi, int lo);
        det = det | mask;
        tick(hi);
        det = det & ~mask;
        tick(lo);
    endtask

    task automatic wait_update(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 2 * W; k++) begin
            @(negedge clock);
            if (bus_d.density_update === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_pos(int pos);
        for (int k = 0; k < W && m_pos != pos; k++) @(negedge clock);
    endtask

    task automatic test_reset();
        int latency;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            n_cmp++;
            if (obs_d !== '0 || obs_b !== '0 || bus_d.density_update !== 1'b0 || bus_b.density_update !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold: got codes %h/%h upd %b/%b, expected 0/0 upd 0/0",
                         obs_d, obs_b, bus_d.density_update, bus_b.density_update);
            end
        end
        clear = 1'b0;
        latency = -1;
        for (int k = 1; k <= 2 * W; k++) begin
            @(negedge clock);
            if (bus_d.density_update === 1'b1) begin
                latency = k;
                break;
            end
        end
        n_cmp++;
        if (latency != W) begin
            n_err++;
            $display("FAIL reset_first_update: got latency %0d, expected %0d", latency, W);
        end
        n_cmp++;
        if (bus_b.density_update !== 1'b1 || obs_d !== exp_d || obs_b !== exp_b ||
            obs_d !== '0 || obs_b !== {4{3'b001}}) begin
            n_err++;
            $display("FAIL reset_first_codes: got %h/%h upd_b %b, expected %h/%h",
                     obs_d, obs_b, bus_b.density_update, exp_d, exp_b);
        end
    endtask

    task automatic test_road_a();
        bit ok;
        det = 4'h0;
        tick(8);
        for (int k = 0; k < 6; k++) pulse(4'b0001, 8, 8);
        wait_update(ok);
        n_cmp++;
        if (!ok || obs_d !== {3'b000, 3'b000, 3'b000, 3'b011} || obs_d !== exp_d || obs_b !== exp_b) begin
            n_err++;
            $display("FAIL road_a: got %h/%h update %b, expected %h/%h", obs_d, obs_b, ok, exp_d, exp_b);
        end
    endtask

    task automatic test_glitch();
        bit ok;
        logic [3:0][2:0] snap_d = obs_d;
        for (int k = 0; k < 12; k++) pulse(4'b0010, 3, 5);
        n_cmp++;
        if (obs_d !== snap_d || bus_d.density_update !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_hold: got %h upd %b, expected %h upd 0", obs_d, bus_d.density_update, snap_d);
        end
        wait_update(ok);
        n_cmp++;
        if (!ok || obs_d !== '0 || obs_b !== '0 || obs_b !== exp_b) begin
            n_err++;
            $display("FAIL glitch_b: got %h/%h update %b, expected 0/0", obs_d, obs_b, ok);
        end
    endtask

    task automatic test_mixed();
        bit ok;
        for (int k = 0; k < 10; k++) pulse(k < 2 ? 4'b1100 : 4'b0100, 8, 8);
        wait_update(ok);
        n_cmp++;
        if (!ok || obs_d !== {3'b001, 3'b111, 3'b000, 3'b000} || obs_d !== exp_d || obs_b !== exp_b) begin
            n_err++;
            $display("FAIL mixed: got %h/%h update %b, expected %h/%h", obs_d, obs_b, ok, exp_d, exp_b);
        end
        wait_update(ok);
        n_cmp++;
        if (!ok || obs_d !== '0 || obs_b !== '0) begin
            n_err++;
            $display("FAIL mixed_quiet: got %h/%h update %b, expected 0/0", obs_d, obs_b, ok);
        end
    endtask

    task automatic test_boundary();
        bit ok;
        wait_pos(W - 1 - DEB);
        det[0] = 1'b1;
        wait_update(ok);
        n_cmp++;
        if (!ok || obs_b !== {3'b000, 3'b000, 3'b000, 3'b001} || obs_d !== '0 || obs_b !== exp_b) begin
            n_err++;
            $display("FAIL boundary_close: got %h/%h update %b, expected 0/001 on road A", obs_d, obs_b, ok);
        end
        tick(4);
        det[0] = 1'b0;
        wait_update(ok);
        n_cmp++;
        if (!ok || obs_b !== '0 || obs_d !== '0) begin
            n_err++;
            $display("FAIL boundary_next: got %h/%h update %b, expected 0/0", obs_d, obs_b, ok);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int latency;
        for (int k = 0; k < 6; k++) pulse(4'b0001, 8, 8);
        wait_update(ok);
        n_cmp++;
        if (!ok || obs_d !== {3'b000, 3'b000, 3'b000, 3'b011}) begin
            n_err++;
            $display("FAIL reset_mid_pre: got %h update %b, expected 003", obs_d, ok);
        end
        for (int k = 0; k < 5; k++) pulse(4'b0010, 8, 8);
        wait_pos(120);
        clear = 1'b1;
        tick(1);
        n_cmp++;
        if (obs_d !== '0 || obs_b !== '0 || bus_d.density_update !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_clear: got %h/%h upd %b, expected 0/0 upd 0",
                     obs_d, obs_b, bus_d.density_update);
        end
        tick(1);
        clear = 1'b0;
        latency = -1;
        for (int k = 1; k <= 2 * W; k++) begin
            @(negedge clock);
            if (bus_d.density_update === 1'b1) begin
                latency = k;
                break;
            end
        end
        n_cmp++;
        if (latency != W || obs_d !== '0 || obs_b !== '0) begin
            n_err++;
            $display("FAIL reset_mid_next: got latency %0d codes %h/%h, expected %0d and 0/0",
                     latency, obs_d, obs_b, W);
        end
    endtask

    task automatic test_random();
        int rate [4];
        for (int c = 0; c < 4 * W; c++) begin
            n_cmp++;
            if (bus_d.density_update !== exp_upd || bus_b.density_update !== exp_upd) begin
                n_err++;
                $display("FAIL random_upd cycle %0d: got %b/%b, expected %b",
                         c, bus_d.density_update, bus_b.density_update, exp_upd);
            end
            n_cmp++;
            if (obs_d !== exp_d || obs_b !== exp_b) begin
                n_err++;
                $display("FAIL random_codes cycle %0d: got %h/%h, expected %h/%h", c, obs_d, obs_b, exp_d, exp_b);
            end
            if (c % W == 0)
                for (int i = 0; i < 4; i++) rate[i] = $urandom_range(3, 40);
            for (int i = 0; i < 4; i++)
                if ($urandom_range(1, rate[i]) == 1) det[i] = ~det[i];
            @(negedge clock);
        end
        det = 4'h0;
    endtask

    initial begin
        test_reset();
        test_road_a();
        test_glitch();
        test_mixed();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tlc_density_sensor.md
# tlc_density_sensor

Front-end conditioning stage that feeds the four-way traffic light controller `tlc`. Takes one raw vehicle-detector line per road (A, B, C, D) and debounces it. Counts vehicle arrivals over a fixed sampling window, then converts each road's count into the 3-bit thermometer density code that `tlc` consumes on `a1..a3`, `b1..b3`, `c1..c3`, `d1..d3`. Outputs are registered and hold steady for a full window, so `tlc` always sees a stable density snapshot.

## Interface
- `WINDOW`, 256: sampling window length in clock cycles (≥2).
- `DEBOUNCE`, 4: consecutive stable cycles required before a detector level change is accepted (≥1).
- `T1`, 2: vehicle count at or above which level bit 1 sets.
- `T2`, 5: threshold for level bit 2.
- `T3`, 9: threshold for level bit 3. Constraint: T1 ≤ T2 ≤ T3.
- `CNT_W`, 8: per-road vehicle counter width.
- `clock`  in  1: single system clock; all logic is rising-edge.
- `clear`  in  1: synchronous, active-high reset.
- `det`  in  4: raw detector lines, bit 0 = A, 1 = B, 2 = C, 3 = D. Same clock domain, may glitch.
- `a1, a2, a3`  out  1 each: road A density thermometer.
- `b1, b2, b3`, `c1, c2, c3`, `d1, d2, d3`  out  1 each: roads B, C, D density thermometers.
- `density_update`  out  1: one-cycle pulse, high in the cycle new density values first appear.

## Operation
- Reset (`clear`=1 at a rising edge): all 12 density outputs, `density_update`, vehicle counters, debounce counters and the window counter go to 0. Debounced levels go to 0.
- Per-road debounce:
  - Filter state is the debounced level `lvl` plus a stability counter.
  - When `det[i]` differs from `lvl`, the counter increments. When it equals `lvl`, the counter resets to 0.
  - When the counter reaches `DEBOUNCE`, `lvl` takes `det[i]` and the counter resets.
  - Result: a raw pulse shorter than `DEBOUNCE` cycles is never seen.
- Arrival: a 0→1 transition of `lvl` is one vehicle. The road counter increments by 1 and saturates at 2^CNT_W−1; it never wraps.
- Window:
  - A free-running counter counts 0..WINDOW−1 and wraps to 0.
  - In the cycle where it equals WINDOW−1 (window close), each road's output register loads the code from that road's count, including any arrival in that same cycle.
  - In the same cycle the road counter resets to 0. The first cycle of the new window counts from 0.
- Code mapping:
  - bit1 = (count ≥ T1), bit2 = (count ≥ T2), bit3 = (count ≥ T3).
  - T1 ≤ T2 ≤ T3 guarantees the legal codes 000, 100, 110, 111 (listed as x1 x2 x3).
  - T1 = 0 forces bit1 = 1 at every close.
- Outputs change only at window close and hold otherwise.
- `clear` mid-window: the window restarts from 0, partial counts are discarded, and outputs return to 0 immediately.

## Timing
- Detector to `lvl`: a raw level change that is held stable is accepted `DEBOUNCE` cycles after its first sampled cycle.
- `lvl` rise to counter increment: 1 cycle.
- Window close to outputs: outputs and `density_update` update on the clock edge ending the WINDOW−1 cycle. They are visible during window cycle 0.
- First update after reset: exactly WINDOW cycles after `clear` deasserts.
- `density_update` is high for exactly 1 cycle per window. It is 0 during reset.
- No handshake: `tlc` samples the outputs freely, and they are stable for WINDOW cycles.

## Structure
- Shared package `tlc_pkg`:
  - road index constants `ROAD_A..ROAD_D` = 0..3, `NUM_ROADS` = 4;
  - default thresholds and `WINDOW`;
  - the 3-bit density code width.
  - `tlc` uses the same package.
- Sub-module `tlc_det_channel`, instantiated 4×. Contents: debounce filter, edge detector, saturating counter, threshold compare and output register. Parameters: `DEBOUNCE`, `T1..T3`, `CNT_W`. Inputs: `clock`, `clear`, `det_i`, `close`. Output: 3-bit code.
- The top level holds the window counter, generates `close`/`density_update`, and fans the codes out to the 12 named outputs.

## Test plan
- Reset: `clear`=1 for 3 cycles with `det`=4'hF.
  - All 12 outputs and `density_update` stay 0.
  - After release, first `density_update` appears exactly 256 cycles later.
- Road A: 6 clean pulses (8 high / 8 low) in window 1. At close: a1=1, a2=1, a3=0; roads B–D read 000.
- Glitch rejection: det[1] gets 12 pulses of 3 cycles high / 5 low → b1=b2=b3=0.
- Mixed:
  - C gets 10 clean pulses → c=111.
  - D gets 2 clean pulses → d=100.
  - Then no activity for one full window → all outputs 000 at the next update.
- Boundary arrival: a debounced rise on A in cycle WINDOW−1 counts toward the closing window, not the next one. Check with T1=1 and a single pulse: a1=1 this window, 0 the next.
- Reset mid-window: 5 pulses on B, then `clear` at window cycle 120 → outputs 0 immediately. Next update comes 256 cycles after release with b=000.
